// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the dual-issue control slice: FSM state, RV32I opcodes
// and field-extract/classification helpers.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SPLIT   = 2'd1,
    LOADUSE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Wide enough for the largest legal reload value (FLUSH_CYCLES-1 = 6).
  localparam int unsigned CNT_W = 3;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic writes_rd(input logic [31:0] instr);
    return !(get_opcode(instr) inside {OP_STORE, OP_BRANCH});
  endfunction

  function automatic logic uses_rs1(input logic [31:0] instr);
    return !(get_opcode(instr) inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [31:0] instr);
    return get_opcode(instr) inside {OP_REG, OP_STORE, OP_BRANCH};
  endfunction

  function automatic logic reads_reg(input logic [31:0] instr, input logic [4:0] r);
    return (uses_rs1(instr) && get_rs1(instr) == r) ||
           (uses_rs2(instr) && get_rs2(instr) == r);
  endfunction

  function automatic logic is_mem(input logic [31:0] instr);
    return get_opcode(instr) inside {OP_LOAD, OP_STORE};
  endfunction

  function automatic logic is_ctrl(input logic [31:0] instr);
    return get_opcode(instr) inside {OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_pair_hazard_check.sv
// Combinational hazard detection for the fetch/decode pair: intra-pair
// conflicts and load-use against the load currently in EX1.
module pair_hazard_check
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  input  logic        ex_load_valid,
  input  logic [4:0]  ex_load_rd,
  output logic        pair_hazard,
  output logic        load_use
);

  logic       valid1;
  logic       valid2;
  logic [4:0] rd1;
  logic       raw;

  always_comb begin
    valid1 = (instr1 != '0);
    valid2 = (instr2 != '0);
    rd1    = get_rd(instr1);
    raw    = writes_rd(instr1) && (rd1 != '0) && reads_reg(instr2, rd1);

    pair_hazard = valid1 && valid2 &&
                  (raw ||
                   (is_mem(instr1) && is_mem(instr2)) ||
                   (is_ctrl(instr1) && is_ctrl(instr2)));

    load_use = ex_load_valid && (ex_load_rd != '0) &&
               ((valid1 && reads_reg(instr1, ex_load_rd)) ||
                (valid2 && reads_reg(instr2, ex_load_rd)));
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue/hazard controller for the dual-issue front end: pair split, load-use
// bubbles, mispredict flush windows and external hold. Optional perf counters
// are enabled by defining DUAL_ISSUE_CTRL_PERF_EN.
module dual_issue_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES    = 2,
  parameter int unsigned LOAD_USE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dec_instr1,
  input  logic [31:0] dec_instr2,
  input  logic        ex_load_valid,
  input  logic [4:0]  ex_load_rd,
  input  logic        mispredict1,
  input  logic        mispredict2,
  input  logic        ext_hold,
  output logic        stall,
  output logic        flush_signal1,
  output logic        flush_signal2,
  output logic        issue1,
  output logic        issue2
`ifdef DUAL_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_split_count,
  output logic [31:0] perf_flush_count
`endif
);

  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LOAD_USE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             flag1, flag2, flag1_n, flag2_n;
  logic             pair_hazard, load_use;
  logic             mispredict;

  pair_hazard_check u_hazard (
    .instr1        (dec_instr1),
    .instr2        (dec_instr2),
    .ex_load_valid (ex_load_valid),
    .ex_load_rd    (ex_load_rd),
    .pair_hazard   (pair_hazard),
    .load_use      (load_use)
  );

  assign mispredict = mispredict1 || mispredict2;

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    flag1_n       = flag1;
    flag2_n       = flag2;
    stall         = 1'b0;
    flush_signal1 = 1'b0;
    flush_signal2 = 1'b0;
    issue1        = 1'b0;
    issue2        = 1'b0;

    if (mispredict) begin
      flush_signal1 = mispredict1;
      flush_signal2 = mispredict2;
      flag1_n       = mispredict1;
      flag2_n       = mispredict2;
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        cnt_n   = FLUSH_RELOAD;
      end else begin
        state_n = RUN;
        cnt_n   = '0;
      end
    end else if (ext_hold) begin
      stall = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            stall = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_n = LOADUSE;
              cnt_n   = LU_RELOAD;
            end
          end else if (pair_hazard) begin
            stall   = 1'b1;
            issue1  = 1'b1;
            state_n = SPLIT;
          end else begin
            issue1 = (dec_instr1 != '0);
            issue2 = (dec_instr2 != '0);
          end
        end
        SPLIT: begin
          issue2  = 1'b1;
          state_n = RUN;
        end
        LOADUSE: begin
          stall = 1'b1;
          if (cnt > CNT_W'(1)) begin
            cnt_n = cnt - CNT_W'(1);
          end else begin
            cnt_n   = '0;
            state_n = RUN;
          end
        end
        FLUSH: begin
          flush_signal1 = flag1;
          flush_signal2 = flag2;
          if (cnt > CNT_W'(1)) begin
            cnt_n = cnt - CNT_W'(1);
          end else begin
            cnt_n   = '0;
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end

    // Outputs are combinational, so the reset must gate them directly.
    if (rst) begin
      stall         = 1'b0;
      flush_signal1 = 1'b0;
      flush_signal2 = 1'b0;
      issue1        = 1'b0;
      issue2        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      flag1 <= 1'b0;
      flag2 <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      flag1 <= flag1_n;
      flag2 <= flag2_n;
    end
  end

`ifdef DUAL_ISSUE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_split_count  <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (state == RUN && state_n == SPLIT && perf_split_count != '1)
        perf_split_count <= perf_split_count + 32'd1;
      if (mispredict && perf_flush_count != '1)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl (FLUSH_CYCLES=2, LOAD_USE_CYCLES=2):
// directed steps push expected outputs, a negedge monitor pops and compares.
module tb_dual_issue_ctrl;

  localparam logic [31:0] ADDI_X1  = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADDI_X2  = 32'h0020_0113; // addi x2,x0,2
  localparam logic [31:0] ADDI_X5  = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] ADD_655  = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] NOP      = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] ADD_600  = 32'h0000_0333; // add x6,x0,x0
  localparam logic [31:0] LW_3_1   = 32'h0000_A183; // lw x3,0(x1)
  localparam logic [31:0] SW_4_2   = 32'h0041_2023; // sw x4,0(x2)
  localparam logic [31:0] BEQ_00   = 32'h0000_0063; // beq x0,x0,0
  localparam logic [31:0] JAL_1    = 32'h0000_00EF; // jal x1,0
  localparam logic [31:0] ADD_870  = 32'h0003_8433; // add x8,x7,x0

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dec_instr1 = '0;
  logic [31:0] dec_instr2 = '0;
  logic        ex_load_valid = 1'b0;
  logic [4:0]  ex_load_rd = '0;
  logic        mispredict1 = 1'b0;
  logic        mispredict2 = 1'b0;
  logic        ext_hold = 1'b0;
  logic        stall, flush_signal1, flush_signal2, issue1, issue2;
`ifdef DUAL_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_split_count, perf_flush_count;
`endif

  typedef struct {
    string      name;
    logic [4:0] v; // {stall, flush1, flush2, issue1, issue2}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dual_issue_ctrl #(
    .FLUSH_CYCLES    (2),
    .LOAD_USE_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_instr1    (dec_instr1),
    .dec_instr2    (dec_instr2),
    .ex_load_valid (ex_load_valid),
    .ex_load_rd    (ex_load_rd),
    .mispredict1   (mispredict1),
    .mispredict2   (mispredict2),
    .ext_hold      (ext_hold),
    .stall         (stall),
    .flush_signal1 (flush_signal1),
    .flush_signal2 (flush_signal2),
    .issue1        (issue1),
    .issue2        (issue2)
`ifdef DUAL_ISSUE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_split_count  (perf_split_count),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  // Monitor: one expected entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {stall, flush_signal1, flush_signal2, issue1, issue2};
      n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {stall,f1,f2,i1,i2}=%b expected %b", e.name, got, e.v);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic lv, input logic [4:0] lrd, input logic m1, input logic m2,
                      input logic h, input logic [4:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst           = r;
    dec_instr1    = a;
    dec_instr2    = b;
    ex_load_valid = lv;
    ex_load_rd    = lrd;
    mispredict1   = m1;
    mispredict2   = m2;
    ext_hold      = h;
    x.name = nm;
    x.v    = e;
    sb.push_back(x);
  endtask

  initial begin
    // Reset, with a mispredict present to prove outputs are gated
    step("rst_a",  1, ADDI_X1, ADDI_X2, 0, 0, 1, 0, 0, 5'b00000);
    step("rst_b",  1, ADDI_X1, ADDI_X2, 0, 0, 1, 1, 0, 5'b00000);
    // Normal issue patterns
    step("indep",  0, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b00011);
    step("raw_n",  0, ADDI_X5, ADD_655, 0, 0, 0, 0, 0, 5'b10010);
    step("raw_n1", 0, ADDI_X5, ADD_655, 0, 0, 0, 0, 0, 5'b00001);
    step("raw_x0", 0, NOP,     ADD_600, 0, 0, 0, 0, 0, 5'b00011);
    step("mem_n",  0, LW_3_1,  SW_4_2,  0, 0, 0, 0, 0, 5'b10010);
    step("mem_n1", 0, LW_3_1,  SW_4_2,  0, 0, 0, 0, 0, 5'b00001);
    step("br_n",   0, BEQ_00,  JAL_1,   0, 0, 0, 0, 0, 5'b10010);
    step("br_n1",  0, BEQ_00,  JAL_1,   0, 0, 0, 0, 0, 5'b00001);
    step("bub2",   0, ADDI_X1, 32'h0,   0, 0, 0, 0, 0, 5'b00010);
    step("bub1",   0, 32'h0,   ADDI_X2, 0, 0, 0, 0, 0, 5'b00001);
    // Load-use: exactly two stall cycles
    step("lu_0",   0, ADD_870, ADDI_X2, 1, 7, 0, 0, 0, 5'b10000);
    step("lu_1",   0, ADD_870, ADDI_X2, 1, 7, 0, 0, 0, 5'b10000);
    step("lu_end", 0, ADD_870, ADDI_X2, 0, 0, 0, 0, 0, 5'b00011);
    step("lu_x0",  0, NOP,     ADD_600, 1, 0, 0, 0, 0, 5'b00011);
    // Load-use from slot 2 with a 3-cycle hold mid-LOADUSE
    step("luh_0",  0, ADDI_X2, ADD_870, 1, 7, 0, 0, 0, 5'b10000);
    step("luh_h1", 0, ADDI_X2, ADD_870, 1, 7, 0, 0, 1, 5'b10000);
    step("luh_h2", 0, ADDI_X2, ADD_870, 1, 7, 0, 0, 1, 5'b10000);
    step("luh_h3", 0, ADDI_X2, ADD_870, 1, 7, 0, 0, 1, 5'b10000);
    step("luh_1",  0, ADDI_X2, ADD_870, 1, 7, 0, 0, 0, 5'b10000);
    step("luh_end",0, ADDI_X2, ADD_870, 0, 0, 0, 0, 0, 5'b00011);
    // Mispredict2 during SPLIT
    step("ms_n",   0, ADDI_X5, ADD_655, 0, 0, 0, 0, 0, 5'b10010);
    step("ms_det", 0, ADDI_X5, ADD_655, 0, 0, 0, 1, 0, 5'b00100);
    step("ms_fl",  0, ADDI_X5, ADD_655, 0, 0, 0, 0, 0, 5'b00100);
    step("ms_run", 0, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b00011);
    // Mispredict outranks ext_hold
    step("mh_det", 0, ADDI_X1, ADDI_X2, 0, 0, 1, 0, 1, 5'b01000);
    step("mh_fl",  0, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b01000);
    step("mh_run", 0, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b00011);
    // New mispredict inside FLUSH reloads and relatches
    step("mr_det", 0, ADDI_X1, ADDI_X2, 0, 0, 1, 0, 0, 5'b01000);
    step("mr_new", 0, ADDI_X1, ADDI_X2, 0, 0, 0, 1, 0, 5'b00100);
    step("mr_fl",  0, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b00100);
    step("mr_run", 0, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b00011);
    // Async reset while in FLUSH
    step("rf_det", 0, ADDI_X1, ADDI_X2, 0, 0, 1, 0, 0, 5'b01000);
    step("rf_rst", 1, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b00000);
`ifdef DUAL_ISSUE_CTRL_PERF_EN
    #2;
    n_cmp++;
    if ({perf_stall_cycles, perf_split_count, perf_flush_count} !== 96'h0) begin
      n_err++;
      $display("FAIL perf_rst: got %0d/%0d/%0d expected 0/0/0",
               perf_stall_cycles, perf_split_count, perf_flush_count);
    end
`endif
    step("rf_run", 0, ADDI_X1, ADDI_X2, 0, 0, 0, 0, 0, 5'b00011);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
